// File: rtl/efx_isg_cam_frame_packer_if.sv
// efx_isg_cam_frame_packer_if: pixel input stream and DMA write stream bundle
interface efx_isg_cam_frame_packer_if #(
  parameter int PPC = 2,
  parameter int PIX_W = 16,
  parameter int DMA_W = 64
);
  logic [PPC*PIX_W-1:0] in_data;
  logic in_valid, in_vs, in_hs;
  logic dma_wvalid, dma_wready, dma_wlast;
  logic [DMA_W-1:0] dma_wdata;
  modport master (output in_data, in_valid, in_vs, in_hs, dma_wready, input dma_wvalid, dma_wlast, dma_wdata);
  modport slave (input in_data, in_valid, in_vs, in_hs, dma_wready, output dma_wvalid, dma_wlast, dma_wdata);
endinterface

// File: rtl/efx_isg_cam_frame_packer.sv
// efx_isg_cam_frame_packer: crops a camera frame window and packs it into DMA beats via a FWFT FIFO
module efx_isg_cam_frame_packer #(
  parameter int PPC = 2,
  parameter int PIX_W = 16,
  parameter int DMA_W = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int CW = 12
) (
  input  logic i_pixel_clk,
  input  logic rstn,
  efx_isg_cam_frame_packer_if.slave bus,
  input  logic cfg_enable,
  input  logic cfg_trigger,
  input  logic cfg_continuous,
  input  logic [CW-1:0] cfg_x_off,
  input  logic [CW-1:0] cfg_y_off,
  input  logic [CW-1:0] cfg_width,
  input  logic [CW-1:0] cfg_height,
  output logic busy,
  output logic frame_done,
  output logic overflow,
  output logic short_frame,
  output logic [15:0] frame_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int GW = PPC * PIX_W;
  localparam int G = DMA_W / GW;
  localparam int IW = G > 1 ? $clog2(G) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DROP, FLUSH, DONE} state_t;
  state_t state_q;
  logic [GW-1:0] data_q;
  logic valid_q, vs_q, hs_q, vs_p_q, hs_p_q, line_q, last_seen_q;
  logic [CW-1:0] x_q, y_q, xo_q, yo_q, w_q, h_q;
  logic [DMA_W-1:0] pack_q, pack_d, push_data_q;
  logic [IW-1:0] idx_q;
  logic push_q, push_last_q;
  logic [DMA_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [CW:0] x_end, y_end;
  logic vs_rise, vs_fall, hs_fall, start, in_win, is_last, grp, beat, full, pop, wr_ok, ovf, wr_en;
  logic [DMA_W:0] wr_data;
  assign busy = state_q != IDLE;
  assign fifo_level = cnt_q;
  assign bus.dma_wvalid = cnt_q != '0;
  assign {bus.dma_wlast, bus.dma_wdata} = cnt_q != '0 ? mem[rd_q] : '0;
  // Edge detection, window test, pack slot insertion and FIFO write arbitration
  always_comb begin
    vs_rise = vs_q && !vs_p_q;
    vs_fall = !vs_q && vs_p_q;
    hs_fall = !hs_q && hs_p_q;
    start = state_q == ARMED && cfg_enable && vs_rise;
    x_end = {1'b0, xo_q} + {1'b0, w_q};
    y_end = {1'b0, yo_q} + {1'b0, h_q};
    in_win = x_q >= xo_q && {1'b0, x_q} < x_end && y_q >= yo_q && {1'b0, y_q} < y_end;
    is_last = {1'b0, x_q} == x_end - (CW+1)'(PPC) && {1'b0, y_q} == y_end - (CW+1)'(1);
    grp = state_q == CAPTURE && valid_q && in_win && !last_seen_q;
    beat = grp && (idx_q == IW'(G - 1) || is_last);
    pack_d = pack_q;
    pack_d[int'(idx_q) * GW +: GW] = data_q;
    full = cnt_q == (AW+1)'(FIFO_DEPTH);
    pop = cnt_q != '0 && bus.dma_wready;
    wr_ok = !full || pop;
    ovf = state_q == CAPTURE && push_q && !wr_ok;
    wr_en = wr_ok && ((state_q == CAPTURE && push_q) || state_q == FLUSH);
    wr_data = state_q == FLUSH ? {1'b1, pack_q} : {push_last_q, push_data_q};
  end
  // Input registers, x/y counters, window latch and the pack register feeding one push stage
  always_ff @(posedge i_pixel_clk or negedge rstn) begin
    if (!rstn) begin
      {data_q, valid_q, vs_q, hs_q, vs_p_q, hs_p_q, line_q, last_seen_q} <= '0;
      {x_q, y_q, xo_q, yo_q, w_q, h_q} <= '0;
      {pack_q, idx_q, push_q, push_last_q, push_data_q} <= '0;
    end else begin
      {data_q, valid_q, vs_q, hs_q} <= {bus.in_data, bus.in_valid, bus.in_vs, bus.in_hs};
      vs_p_q <= vs_q;
      hs_p_q <= hs_q;
      if (start) begin
        {x_q, y_q, line_q} <= '0;
        {xo_q, yo_q, w_q, h_q} <= {cfg_x_off, cfg_y_off, cfg_width, cfg_height};
      end else if (hs_fall) begin
        x_q <= '0;
        line_q <= 1'b0;
        y_q <= y_q + CW'(line_q || valid_q);
      end else if (valid_q) begin
        x_q <= x_q + CW'(PPC);
        line_q <= 1'b1;
      end
      if (start) begin
        {pack_q, idx_q, last_seen_q} <= '0;
      end else if (grp) begin
        pack_q <= beat ? '0 : pack_d;
        idx_q <= beat ? '0 : idx_q + 1'b1;
        last_seen_q <= is_last;
      end else if (state_q == FLUSH && wr_ok) begin
        {pack_q, idx_q} <= '0;
      end
      push_q <= beat;
      push_last_q <= is_last;
      push_data_q <= pack_d;
    end
  end
  // Capture state machine plus sticky flags and frame completion status
  always_ff @(posedge i_pixel_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      {overflow, short_frame, frame_done, frame_count} <= '0;
    end else begin
      case (state_q)
        IDLE:    state_q <= cfg_trigger && cfg_enable ? ARMED : IDLE;
        ARMED:   state_q <= !cfg_enable ? IDLE : vs_rise ? CAPTURE : ARMED;
        CAPTURE: state_q <= ovf ? DROP : push_q && push_last_q ? DONE : vs_fall && !last_seen_q ? FLUSH : CAPTURE;
        DROP:    state_q <= vs_fall ? FLUSH : DROP;
        FLUSH:   state_q <= wr_ok ? DONE : FLUSH;
        default: state_q <= cfg_continuous && cfg_enable ? ARMED : IDLE;
      endcase
      overflow <= ovf || (overflow && !cfg_trigger);
      short_frame <= (state_q == CAPTURE && !ovf && !(push_q && push_last_q) && vs_fall && !last_seen_q) || (short_frame && !cfg_trigger);
      frame_done <= pop && bus.dma_wlast;
      frame_count <= frame_count + 16'(pop && bus.dma_wlast);
    end
  end
  // FIFO pointers and occupancy
  always_ff @(posedge i_pixel_clk or negedge rstn) begin
    if (!rstn) begin
      {wr_q, rd_q, cnt_q} <= '0;
    end else begin
      wr_q <= wr_q + AW'(wr_en);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end
  // FIFO storage, read combinationally for first-word-fall-through
  always_ff @(posedge i_pixel_clk) begin
    if (wr_en) mem[wr_q] <= wr_data;
  end
endmodule
